skid_buf_62: RTL and testbench
==============================

SKID_BUF_62 -- requirements
Module: skid_buf_62

Interface
REQ-001 Parameter: WIDTH, default 62, payload width in bits.
REQ-002 clk  input  1  single clock; all flops update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 out_data  output  WIDTH  head-of-buffer payload.
REQ-011 occupancy  output  2  number of buffered words, 0..2.

Function
REQ-012 The block SHALL define in_fire as in_valid & in_ready, and out_fire as out_valid & out_ready.
REQ-013 The block SHALL hold two entries, main and skid; out_data SHALL always equal main.
REQ-014 The block SHALL implement states EMPTY (0 words), ONE (main valid) and FULL (main and skid valid).
REQ-015 out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; in_ready SHALL be driven from state flops only, with no combinational path from out_ready or in_valid.
REQ-017 In EMPTY, in_fire SHALL load main with in_data and move to ONE.
REQ-018 In ONE, in_fire & out_fire SHALL load main with in_data and stay in ONE.
REQ-019 In ONE, out_fire alone SHALL move to EMPTY.
REQ-020 In ONE, in_fire alone SHALL load skid with in_data and move to FULL.
REQ-021 In ONE, no fire SHALL hold state and data.
REQ-022 In FULL, out_fire SHALL copy skid into main and move to ONE; no in_fire is possible in FULL.
REQ-023 Latency SHALL be exactly 1 cycle from in_fire to out_valid when the buffer is empty.
REQ-024 Sustained throughput SHALL be 1 word per cycle while out_ready is held high.
REQ-025 Words SHALL leave in acceptance order, with no loss or duplication.
REQ-026 flush SHALL force EMPTY on the next edge, overriding any fire in the same cycle; a word accepted during flush is dropped.
REQ-027 Data registers MAY retain stale values after flush; only out_valid and occupancy SHALL reflect the flush.
REQ-028 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE and FULL respectively.
REQ-029 out_data SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-030 While rst_n=0, the block SHALL be in EMPTY, with main=0, skid=0, out_valid=0, in_ready=1 and occupancy=0, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard all entries; the first in_fire after release SHALL be the first word output.

Structure
REQ-032 State encoding (EMPTY/ONE/FULL) SHALL live in the shared pipeline package npc_pipe_pkg.
REQ-033 One sub-module, skid_data_reg, SHALL be used: a WIDTH-wide register with load enable and asynchronous active-low clear to 0, instantiated for main and skid.
REQ-034 Control SHALL be a single next-state/enable process in skid_buf_62.

Verification
REQ-035 Reset then in_valid=1, in_data=62'h1 with out_ready=1 -> out_valid=1 and out_data=62'h1 on the next cycle, and occupancy=1.
REQ-036 Stream 0x10..0x1F with out_ready=1 continuously -> 16 words output in order on 16 consecutive cycles, with in_ready never 0.
REQ-037 out_ready=0 while offering 0xA then 0xB -> occupancy=2 and in_ready=0; then out_ready=1 -> 0xA then 0xB output on consecutive cycles, and in_ready returns to 1 the cycle after the 0xA fire.
REQ-038 FULL with flush=1 and in_valid=1 (0xC) in the same cycle -> next cycle out_valid=0, occupancy=0, and 0xC is never output.
REQ-039 rst_n pulsed low asynchronously mid-cycle while in FULL -> out_valid=0 and in_ready=1 immediately; the next word offered (0x5) is the first word output.
REQ-040 Random in_valid/out_ready, 10k cycles -> scoreboard shows no loss, duplication or reordering, out_data stable under backpressure, and occupancy equal to accepted minus output words.

Source files
------------

// File: rtl/npc_pipe_pkg.sv
// Shared pipeline definitions: state encoding for two-entry skid buffers
// and a helper that turns a state into a word count.
package npc_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // The encoding is the word count, so occupancy falls straight out of the state.
  function automatic logic [1:0] occ_of(skid_state_e s);
    return logic'(1'b0) ? 2'd0 : 2'(s);
  endfunction

endpackage

// File: rtl/skid_data_reg.sv
// WIDTH-wide payload register with load enable and asynchronous clear to zero.
module skid_data_reg #(
  parameter int WIDTH = 62
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: payload is cleared on reset so out_data reads 0 while empty after reset;
  // the data path alone does not need it, validity is carried by the state flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_buf_62.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs one
// word of backpressure so in_ready depends only on state flops.
module skid_buf_62
  import npc_pipe_pkg::*;
#(
  parameter int WIDTH = 62
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e      state_q, state_d;
  logic             main_load, skid_load, main_from_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign occupancy = occ_of(state_q);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any handshake in the same cycle; the accepted word is dropped.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  skid_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  skid_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_skid_buf_62.sv
// Directed and randomized checks for skid_buf_62 against hand-computed values
// and a queue model of accepted words.
module tb_skid_buf_62;

  localparam int WIDTH = 62;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] model_q[$];

  always #5 clk = ~clk;

  skid_buf_62 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".in_ready"},  64'(in_ready),  64'd1);
    check({tag, ".occupancy"}, 64'(occupancy), 64'd0);
  endtask

  initial begin
    bit iv, ordy;
    logic [WIDTH-1:0] d;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state, observed before any clock edge
    #3;
    check_idle("reset");
    check("reset.out_data", 64'(out_data), 64'd0);
    #4 rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Single word, one-cycle latency
    in_valid = 1'b1; in_data = 62'h1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single.out_valid", 64'(out_valid), 64'd1);
    check("single.out_data",  64'(out_data),  64'h1);
    check("single.occupancy", 64'(occupancy), 64'd1);
    tick();
    check_idle("single_drain");

    // Streaming 0x10..0x1F at full rate
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(32'h10 + i);
      check($sformatf("stream.in_ready[%0d]", i), 64'(in_ready), 64'd1);
      tick();
      check($sformatf("stream.out_valid[%0d]", i), 64'(out_valid), 64'd1);
      check($sformatf("stream.out_data[%0d]", i), 64'(out_data), 64'h10 + 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check_idle("stream_drain");

    // Backpressure fills both entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 62'hA;
    tick();
    in_data = 62'hB;
    tick();
    in_valid = 1'b0;
    check("bp.occupancy", 64'(occupancy), 64'd2);
    check("bp.in_ready",  64'(in_ready),  64'd0);
    check("bp.out_data",  64'(out_data),  64'hA);
    tick();
    check("bp.hold_data", 64'(out_data),  64'hA);
    check("bp.hold_occ",  64'(occupancy), 64'd2);
    out_ready = 1'b1;
    check("bp.first_valid", 64'(out_valid), 64'd1);
    tick();
    check("bp.second_data", 64'(out_data),  64'hB);
    check("bp.in_ready_back", 64'(in_ready), 64'd1);
    check("bp.occ_one",     64'(occupancy), 64'd1);
    tick();
    check_idle("bp_drain");

    // Flush while FULL with a word offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 62'h21;
    tick();
    in_data = 62'h22;
    tick();
    check("flush_full.occ_before", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 62'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush_full");

    // Flush in ONE overriding a same-cycle accept
    in_valid = 1'b1; in_data = 62'h30;
    tick();
    flush = 1'b1; in_data = 62'hC; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush_one");
    tick();
    check_idle("flush_one_stays");
    in_valid = 1'b1; in_data = 62'h31;
    tick();
    in_valid = 1'b0;
    check("after_flush.out_data", 64'(out_data), 64'h31);
    tick();
    check_idle("after_flush_drain");

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 62'h41;
    tick();
    in_data = 62'h42;
    tick();
    in_valid = 1'b0;
    check("areset.occ_before", 64'(occupancy), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check_idle("areset");
    check("areset.out_data", 64'(out_data), 64'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 62'h5;
    tick();
    in_valid = 1'b0;
    check("areset.first_valid", 64'(out_valid), 64'd1);
    check("areset.first_data",  64'(out_data),  64'h5);
    tick();
    check_idle("areset_drain");

    // Random handshakes against a queue model
    model_q.delete();
    for (int c = 0; c < 10000; c++) begin
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      d    = {$urandom, $urandom};
      in_valid = iv; out_ready = ordy; in_data = d;
      check("rnd.out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      check("rnd.in_ready",  64'(in_ready),  64'(model_q.size() < 2));
      check("rnd.occupancy", 64'(occupancy), 64'(model_q.size()));
      if (model_q.size() > 0) check("rnd.out_data", 64'(out_data), 64'(model_q[0]));
      if (ordy && model_q.size() > 0) begin
        if (iv && model_q.size() < 2) model_q.push_back(d);
        void'(model_q.pop_front());
      end else if (iv && model_q.size() < 2) begin
        model_q.push_back(d);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check_idle("rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
